// File: rtl/mpu_initiator_if.sv
// Shared MPU types plus the request/status bus between the initiator and the MPU.
//   mpu_initiator_pkg : mpu_error_t response codes
//   mpu_initiator_if  : cs/cfg/we/free_reserve/core_id/addr/wdata toward the MPU,
//                       rdy/bsy/rdata/err/source_core_id back from it.
//   modport master    : the initiator (drives the request fields)
//   modport slave     : the MPU (drives status and read data)
package mpu_initiator_pkg;
    typedef enum logic [1:0] {
        MPU_NO_ERROR       = 2'd0,
        MPU_ACCESS_GRANTED = 2'd1,
        MPU_ACCESS_DENIED  = 2'd2,
        MPU_OUT_OF_MEMORY  = 2'd3
    } mpu_error_t;
endpackage

interface mpu_initiator_if #(
    parameter int CORE_ID_WIDTH = 2,
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16
);
    import mpu_initiator_pkg::*;

    logic                     cs;
    logic                     cfg;
    logic                     we;
    logic                     free_reserve;
    logic [CORE_ID_WIDTH-1:0] core_id;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic                     rdy;
    logic                     bsy;
    logic [DATA_WIDTH-1:0]    rdata;
    mpu_error_t               err;
    logic [CORE_ID_WIDTH-1:0] source_core_id;

    modport master (
        output cs, cfg, we, free_reserve, core_id, addr, wdata,
        input  rdy, bsy, rdata, err, source_core_id
    );

    modport slave (
        input  cs, cfg, we, free_reserve, core_id, addr, wdata,
        output rdy, bsy, rdata, err, source_core_id
    );
endinterface

// File: rtl/mpu_initiator.sv
// Requester-side front end for the MPU. Round-robin arbitrates NUM_CORES request
// ports, issues one MPU transaction at a time and returns the result to the
// originating core on a one-cycle rsp_valid pulse.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*             per-core request (valid/ready handshake, packed addr/wdata)
//   rsp_*             one-hot response pulse with shared rdata/err/timeout
//   protocol_err      sticky flag: MPU echoed the wrong core id
//   mpu               MPU bus (master modport)
//
// state  | meaning
// S_ARB   | idle; grant the next requesting core when the MPU is not busy
// S_ISSUE | mpu_cs high for one cycle with the latched request
// S_WAIT  | wait for mpu_rdy, counting toward the timeout
// S_RESP  | rsp_valid pulse to the granted core
// S_FLUSH | after a timeout, swallow the late mpu_rdy before re-arbitrating
module mpu_initiator
    import mpu_initiator_pkg::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int CORE_ID_WIDTH  = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CORES-1:0]            req_valid,
    output logic [NUM_CORES-1:0]            req_ready,
    input  logic [NUM_CORES-1:0]            req_cfg,
    input  logic [NUM_CORES-1:0]            req_we,
    input  logic [NUM_CORES-1:0]            req_free_reserve,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_CORES-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output mpu_error_t                      rsp_err,
    output logic                            rsp_timeout,
    output logic                            protocol_err,
    mpu_initiator_if.master                 mpu
);

    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [2:0] {S_ARB, S_ISSUE, S_WAIT, S_RESP, S_FLUSH} state_t;

    state_t                   state_q, state_d;
    logic [CORE_ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [CORE_ID_WIDTH-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     timed_out_q, timed_out_d;
    logic                     cs_q, cs_d;
    logic                     cfg_q, cfg_d;
    logic                     we_q, we_d;
    logic                     fr_q, fr_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [NUM_CORES-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    mpu_error_t               rsp_err_q, rsp_err_d;
    logic                     rsp_timeout_q, rsp_timeout_d;
    logic                     prot_q, prot_d;

    logic                     pick_vld;
    logic [CORE_ID_WIDTH-1:0] pick_idx;

    // Scan from the highest offset down so the lowest offset past the pointer wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (req_valid[CORE_ID_WIDTH'(idx)]) begin
                pick_vld = 1'b1;
                pick_idx = CORE_ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        cnt_d         = cnt_q;
        timed_out_d   = timed_out_q;
        cs_d          = 1'b0;
        cfg_d         = cfg_q;
        we_d          = we_q;
        fr_d          = fr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = '0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        prot_d        = prot_q;
        req_ready     = '0;

        case (state_q)
            S_ARB: begin
                if (!mpu.bsy && pick_vld) begin
                    req_ready[pick_idx] = 1'b1;
                    gnt_d   = pick_idx;
                    cfg_d   = req_cfg[pick_idx];
                    we_d    = req_we[pick_idx];
                    fr_d    = req_free_reserve[pick_idx];
                    addr_d  = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    ptr_d   = (pick_idx == CORE_ID_WIDTH'(NUM_CORES - 1)) ?
                              '0 : pick_idx + CORE_ID_WIDTH'(1);
                    cs_d    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // rdy is tested first so it wins over a timeout expiring the same cycle.
                if (mpu.rdy) begin
                    rsp_valid_d   = NUM_CORES'(1) << gnt_q;
                    rsp_rdata_d   = mpu.rdata;
                    rsp_timeout_d = 1'b0;
                    if (mpu.source_core_id != gnt_q) begin
                        prot_d    = 1'b1;
                        rsp_err_d = MPU_ACCESS_DENIED;
                    end else begin
                        rsp_err_d = mpu.err;
                    end
                    state_d = S_RESP;
                end else if (TO_EN && cnt_q == CNT_W'(TO_LAST)) begin
                    rsp_valid_d   = NUM_CORES'(1) << gnt_q;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = MPU_ACCESS_DENIED;
                    rsp_timeout_d = 1'b1;
                    timed_out_d   = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = timed_out_q ? S_FLUSH : S_ARB;
            end
            S_FLUSH: begin
                if (mpu.rdy) begin
                    timed_out_d = 1'b0;
                    state_d     = S_ARB;
                end
            end
            default: state_d = S_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_ARB;
            ptr_q         <= '0;
            gnt_q         <= '0;
            cnt_q         <= '0;
            timed_out_q   <= 1'b0;
            cs_q          <= 1'b0;
            cfg_q         <= 1'b0;
            we_q          <= 1'b0;
            fr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= MPU_NO_ERROR;
            rsp_timeout_q <= 1'b0;
            prot_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            cnt_q         <= cnt_d;
            timed_out_q   <= timed_out_d;
            cs_q          <= cs_d;
            cfg_q         <= cfg_d;
            we_q          <= we_d;
            fr_q          <= fr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            prot_q        <= prot_d;
        end
    end

    assign mpu.cs           = cs_q;
    assign mpu.cfg          = cfg_q;
    assign mpu.we           = we_q;
    assign mpu.free_reserve = fr_q;
    assign mpu.core_id      = gnt_q;
    assign mpu.addr         = addr_q;
    assign mpu.wdata        = wdata_q;

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign protocol_err = prot_q;

endmodule

// File: tb/tb_mpu_initiator.sv
module tb_mpu_initiator;
    import mpu_initiator_pkg::*;

    localparam int N   = 4;
    localparam int CID = 2;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TO  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_cfg = '0;
    logic [N-1:0]    req_we = '0;
    logic [N-1:0]    req_fr = '0;
    logic [AW-1:0]   c_addr [N];
    logic [DW-1:0]   c_wdata [N];
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    mpu_error_t      rsp_err;
    logic            rsp_timeout;
    logic            protocol_err;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_addr[gi*AW +: AW]  = c_addr[gi];
        assign req_wdata[gi*DW +: DW] = c_wdata[gi];
    end

    mpu_initiator_if #(.CORE_ID_WIDTH(CID), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mpu_if ();

    mpu_initiator #(
        .NUM_CORES(N), .CORE_ID_WIDTH(CID), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cfg(req_cfg), .req_we(req_we), .req_free_reserve(req_fr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .protocol_err(protocol_err),
        .mpu(mpu_if)
    );

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;     // reference round-robin pointer
    bit m_prot = 1'b0;  // reference sticky protocol error

    typedef struct {
        int            core;
        logic          cfg, we, fr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            dly;
        logic [DW-1:0] rd;
        mpu_error_t    er;
        int            src;      // -1: MPU echoes the granted id
        logic [DW-1:0] exp_rd;
        mpu_error_t    exp_err;
        logic          exp_prot;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int g);
        return N'(1) << g;
    endfunction

    // Raise mask, expect an immediate grant to the model's pick, step into ISSUE and
    // check the MPU request fields. g=-1 if no grant ever appears.
    task automatic grant_issue(input logic [N-1:0] mask, input bit keep, output int g);
        int w;
        int exp_g;
        req_valid = req_valid | mask;
        #1;
        exp_g = rr_pick(req_valid, m_ptr);
        w = 0;
        while (req_ready == '0 && w < 20) begin
            tick();
            w++;
        end
        chk("grant_latency", 32'(w), 32'd0);
        if (w >= 20) begin
            g = -1;
            return;
        end
        chk("req_ready", 32'(req_ready), 32'(oh(exp_g)));
        chk("no_rsp_with_ready", 32'(rsp_valid), 32'd0);
        g = exp_g;
        m_ptr = (g + 1) % N;
        tick();
        if (!keep) req_valid[g] = 1'b0;
        chk("issue_cs", 32'(mpu_if.cs), 32'd1);
        chk("issue_core_id", 32'(mpu_if.core_id), 32'(g));
        chk("issue_cfg", 32'(mpu_if.cfg), 32'(req_cfg[g]));
        chk("issue_we", 32'(mpu_if.we), 32'(req_we[g]));
        chk("issue_fr", 32'(mpu_if.free_reserve), 32'(req_fr[g]));
        chk("issue_addr", 32'(mpu_if.addr), 32'(c_addr[g]));
        chk("issue_wdata", 32'(mpu_if.wdata), 32'(c_wdata[g]));
        chk("issue_no_ready", 32'(req_ready), 32'd0);
    endtask

    task automatic finish_rsp(input int g, input int dly, input logic [DW-1:0] rd,
                              input mpu_error_t er, input int srcv,
                              input logic [DW-1:0] exp_rd, input mpu_error_t exp_err,
                              input logic exp_prot);
        if (g < 0) return;
        tick();
        chk("wait_cs_low", 32'(mpu_if.cs), 32'd0);
        chk("wait_addr_stable", 32'(mpu_if.addr), 32'(c_addr[g]));
        repeat (dly) tick();
        chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
        mpu_if.rdy            = 1'b1;
        mpu_if.rdata          = rd;
        mpu_if.err            = er;
        mpu_if.source_core_id = (srcv < 0) ? CID'(g) : CID'(srcv);
        tick();
        mpu_if.rdy   = 1'b0;
        mpu_if.rdata = DW'($urandom);
        chk("rsp_valid", 32'(rsp_valid), 32'(oh(g)));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("protocol_err", 32'(protocol_err), 32'(exp_prot));
        chk("rsp_no_ready", 32'(req_ready), 32'd0);
        tick();
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int g;
        int srcv;
        int gp;
        logic [N-1:0] mask;
        mpu_error_t er;
        mpu_error_t ee;
        logic [DW-1:0] rd;

        for (int c = 0; c < N; c++) begin
            c_addr[c]  = '0;
            c_wdata[c] = '0;
        end
        mpu_if.rdy = 1'b0;
        mpu_if.bsy = 1'b1;
        mpu_if.rdata = '0;
        mpu_if.err = MPU_NO_ERROR;
        mpu_if.source_core_id = '0;

        //                core cfg   we    fr    addr      wdata     dly rd        er                  src exp_rd    exp_err             prot
        tbl[0] = '{2, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 2, 16'h00A5, MPU_ACCESS_GRANTED, -1, 16'h00A5, MPU_ACCESS_GRANTED, 1'b0};
        tbl[1] = '{1, 1'b1, 1'b0, 1'b0, 16'h8000, 16'h0010, 0, 16'h0040, MPU_NO_ERROR,       -1, 16'h0040, MPU_NO_ERROR,       1'b0};
        tbl[2] = '{3, 1'b0, 1'b1, 1'b0, 16'h0042, 16'hBEEF, 7, 16'h0000, MPU_ACCESS_GRANTED, -1, 16'h0000, MPU_ACCESS_GRANTED, 1'b0};
        tbl[3] = '{0, 1'b1, 1'b0, 1'b1, 16'h8040, 16'h0000, 1, 16'h0000, MPU_OUT_OF_MEMORY,  -1, 16'h0000, MPU_OUT_OF_MEMORY,  1'b0};
        tbl[4] = '{0, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 3, 16'h0077, MPU_ACCESS_GRANTED,  3, 16'h0077, MPU_ACCESS_DENIED,  1'b1};
        tbl[5] = '{1, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h1111, 0, 16'h0011, MPU_ACCESS_GRANTED, -1, 16'h0011, MPU_ACCESS_GRANTED, 1'b1};

        // Reset state
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'(MPU_NO_ERROR));
        chk("rst_prot", 32'(protocol_err), 32'd0);
        chk("rst_cs", 32'(mpu_if.cs), 32'd0);
        chk("rst_addr", 32'(mpu_if.addr), 32'd0);

        // MPU busy after reset holds off the grant
        rst_n = 1'b1;
        req_valid[0] = 1'b1;
        c_addr[0] = 16'h0ABC;
        repeat (10) begin
            #1;
            chk("bsy_no_ready", 32'(req_ready), 32'd0);
            chk("bsy_no_cs", 32'(mpu_if.cs), 32'd0);
            tick();
        end
        mpu_if.bsy = 1'b0;
        grant_issue(4'b0001, 1'b0, g);
        finish_rsp(g, 0, 16'h0005, MPU_ACCESS_GRANTED, -1, 16'h0005, MPU_ACCESS_GRANTED, 1'b0);

        // Directed table
        foreach (tbl[i]) begin
            req_cfg[tbl[i].core] = tbl[i].cfg;
            req_we[tbl[i].core]  = tbl[i].we;
            req_fr[tbl[i].core]  = tbl[i].fr;
            c_addr[tbl[i].core]  = tbl[i].addr;
            c_wdata[tbl[i].core] = tbl[i].wdata;
            grant_issue(oh(tbl[i].core), 1'b0, g);
            chk("tbl_grant", 32'(g), 32'(tbl[i].core));
            finish_rsp(g, tbl[i].dly, tbl[i].rd, tbl[i].er, tbl[i].src,
                       tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_prot);
            m_prot = tbl[i].exp_prot;
        end

        // Timeout, flush of the late rdy, then a normal grant
        grant_issue(4'b0100, 1'b0, g);
        if (g >= 0) begin
            tick();
            repeat (7) begin
                chk("to_no_rsp", 32'(rsp_valid), 32'd0);
                tick();
            end
            chk("to_no_rsp_last", 32'(rsp_valid), 32'd0);
            tick();
            chk("to_rsp_valid", 32'(rsp_valid), 32'(oh(2)));
            chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
            chk("to_rsp_err", 32'(rsp_err), 32'(MPU_ACCESS_DENIED));
            chk("to_rsp_rdata", 32'(rsp_rdata), 32'd0);
            req_valid[1] = 1'b1;
            c_addr[1] = 16'h0303;
            tick();
            chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
            chk("flush_no_ready", 32'(req_ready), 32'd0);
            tick();
            chk("flush_no_ready2", 32'(req_ready), 32'd0);
            mpu_if.rdy = 1'b1;
            mpu_if.rdata = 16'hDEAD;
            mpu_if.source_core_id = 2'd2;
            tick();
            mpu_if.rdy = 1'b0;
            chk("late_rdy_swallowed", 32'(rsp_valid), 32'd0);
            chk("post_flush_ready", 32'(req_ready), 32'(oh(1)));
            grant_issue(4'b0010, 1'b0, g);
            finish_rsp(g, 4, 16'h0909, MPU_ACCESS_GRANTED, -1, 16'h0909, MPU_ACCESS_GRANTED, m_prot);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 24; i++) begin
            mask = N'($urandom_range(1, 15));
            for (int c = 0; c < N; c++) begin
                if (!req_valid[c]) begin
                    c_addr[c]  = AW'($urandom);
                    c_wdata[c] = DW'($urandom);
                    req_cfg[c] = 1'($urandom);
                    req_we[c]  = 1'($urandom);
                    req_fr[c]  = 1'($urandom);
                end
            end
            gp   = rr_pick(req_valid | mask, m_ptr);
            srcv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            rd   = DW'($urandom);
            er   = mpu_error_t'($urandom_range(0, 3));
            ee   = (srcv >= 0 && srcv != gp) ? MPU_ACCESS_DENIED : er;
            if (srcv >= 0 && srcv != gp) m_prot = 1'b1;
            grant_issue(mask, 1'b0, g);
            finish_rsp(g, $urandom_range(0, TO - 1), rd, er, srcv, rd, ee, m_prot);
        end
        req_valid = '0;
        tick();

        // Reset mid-transaction drops it
        grant_issue(4'b1000, 1'b0, g);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_cs", 32'(mpu_if.cs), 32'd0);
        chk("mrst_prot", 32'(protocol_err), 32'd0);
        chk("mrst_rsp_err", 32'(rsp_err), 32'(MPU_NO_ERROR));
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
        m_prot = 1'b0;
        mpu_if.rdy = 1'b1;
        mpu_if.source_core_id = 2'd3;
        tick();
        mpu_if.rdy = 1'b0;
        chk("mrst_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("mrst_no_rsp2", 32'(rsp_valid), 32'd0);

        // All cores requesting continuously: 0,1,2,3,0
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            grant_issue(4'b1111, 1'b1, g);
            chk("rr_order", 32'(g), 32'(i % N));
            finish_rsp(g, i, DW'(16'h0100 + i), MPU_ACCESS_GRANTED, -1,
                       DW'(16'h0100 + i), MPU_ACCESS_GRANTED, 1'b0);
        end
        req_valid = '0;
        tick();
        chk("idle_cs", 32'(mpu_if.cs), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1, "time limit");
    end

endmodule
